// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: one requester's link to the ALU arbiter.
//   Request side : req_valid, req_ready, req_a, req_b, req_op (3-bit ALUop)
//   Response side: resp_valid, resp_ready, resp_result, resp_flags {Overflow, CarryOut, Zero}
//   master = requester (client), slave = arbiter.
interface alu_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic [DATA_WIDTH-1:0] req_a;
  logic [DATA_WIDTH-1:0] req_b;
  logic [2:0]            req_op;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_result;
  logic [2:0]            resp_flags;

  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_flags
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready,
    output req_ready, resp_valid, resp_result, resp_flags
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// Round-robin arbitration in IDLE, one EXEC cycle driving the ALU from latched
// operands, then the registered result/flags are held for the issuing requester.
//   clk, rst          : clock, asynchronous active-high reset
//   io_req0, io_req1  : requester links (slave side)
//   o_alu_a/b/op      : operands and ALUop to the ALU
//   i_alu_result      : ALU result
//   i_alu_overflow, i_alu_carry_out, i_alu_zero : ALU flags
module alu_arbiter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_arbiter_if.slave          io_req0,
  alu_arbiter_if.slave          io_req1,
  output logic [DATA_WIDTH-1:0] o_alu_a,
  output logic [DATA_WIDTH-1:0] o_alu_b,
  output logic [2:0]            o_alu_op,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic                  i_alu_overflow,
  input  logic                  i_alu_carry_out,
  input  logic                  i_alu_zero
);

  typedef enum logic [1:0] {StIdle = 2'd0, StExec = 2'd1, StResp = 2'd2} state_e;

  state_e                r_state;
  state_e                w_state_next;
  logic                  r_rr_ptr;
  logic                  r_owner;
  logic [DATA_WIDTH-1:0] r_opnd_a;
  logic [DATA_WIDTH-1:0] r_opnd_b;
  logic [2:0]            r_opnd_op;
  logic [DATA_WIDTH-1:0] r_res0;
  logic [DATA_WIDTH-1:0] r_res1;
  logic [2:0]            r_flags0;
  logic [2:0]            r_flags1;

  logic w_any_valid;
  logic w_grant;
  logic w_accept;
  logic w_resp_ready;

  assign w_any_valid = io_req0.req_valid | io_req1.req_valid;
  // Only requester 1 valid picks 1; only 0 valid picks 0; both valid defer to rr_ptr.
  assign w_grant = (io_req0.req_valid & io_req1.req_valid) ? r_rr_ptr : io_req1.req_valid;
  // The granted requester is always a valid one, so any valid in IDLE is an accept.
  assign w_accept     = (r_state == StIdle) & w_any_valid;
  assign w_resp_ready = r_owner ? io_req1.resp_ready : io_req0.resp_ready;

  // The ALU sees the operand registers directly; they only change on accept, so
  // the ALU inputs hold their last value outside EXEC.
  assign o_alu_a  = r_opnd_a;
  assign o_alu_b  = r_opnd_b;
  assign o_alu_op = r_opnd_op;

  assign io_req0.resp_result = r_res0;
  assign io_req0.resp_flags  = r_flags0;
  assign io_req1.resp_result = r_res1;
  assign io_req1.resp_flags  = r_flags1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_any_valid) w_state_next = StExec;
      StExec:  w_state_next = StResp;
      StResp:  if (w_resp_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    io_req0.req_ready  = w_accept & ~w_grant;
    io_req1.req_ready  = w_accept & w_grant;
    io_req0.resp_valid = (r_state == StResp) & ~r_owner;
    io_req1.resp_valid = (r_state == StResp) & r_owner;
  end

  // Operand latch, arbitration pointer and per-requester response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr  <= 1'b0;
      r_owner   <= 1'b0;
      r_opnd_a  <= '0;
      r_opnd_b  <= '0;
      r_opnd_op <= '0;
      r_res0    <= '0;
      r_res1    <= '0;
      r_flags0  <= '0;
      r_flags1  <= '0;
    end else begin
      if (w_accept) begin
        r_owner   <= w_grant;
        r_rr_ptr  <= ~w_grant;
        r_opnd_a  <= w_grant ? io_req1.req_a  : io_req0.req_a;
        r_opnd_b  <= w_grant ? io_req1.req_b  : io_req0.req_b;
        r_opnd_op <= w_grant ? io_req1.req_op : io_req0.req_op;
      end
      // Only the owner's registers are written; the other side keeps its last response.
      if (r_state == StExec) begin
        if (r_owner) begin
          r_res1   <= i_alu_result;
          r_flags1 <= {i_alu_overflow, i_alu_carry_out, i_alu_zero};
        end else begin
          r_res0   <= i_alu_result;
          r_flags0 <= {i_alu_overflow, i_alu_carry_out, i_alu_zero};
        end
      end
    end
  end

endmodule
